// File: rtl/whack_pkg.sv
// Shared definitions for the whack-a-mole judge and display controller.
package whack_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ARMED = 2'd2,
    CLEAR = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } score_t;

  localparam int SCORE_MAX = 99;

  // Bit positions of the mole lines, shared with the display controller.
  localparam int MOLE1 = 0;
  localparam int MOLE2 = 1;
  localparam int MOLE3 = 2;

  function automatic logic mole_lit(logic [2:0] m);
    return (m == 3'(1 << MOLE1)) || (m == 3'(1 << MOLE2)) || (m == 3'(1 << MOLE3));
  endfunction

  // Saturating BCD increment.
  function automatic score_t bcd_inc(score_t s);
    score_t r;
    r = s;
    if (int'(s.tens) * 10 + int'(s.ones) < SCORE_MAX) begin
      if (s.ones == 4'd9) begin
        r.ones = 4'd0;
        r.tens = s.tens + 4'd1;
      end else begin
        r.ones = s.ones + 4'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/whack_judge_key_edge.sv
// Push-button synchronizer and rising-edge detector; press is registered.
module key_edge #(
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [W-1:0] key,
  output logic [W-1:0] press
);

  logic [W-1:0] sync1, sync2, sync3;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
      press <= '0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      sync3 <= sync2;
      press <= sync2 & ~sync3;
    end
  end

endmodule

// File: rtl/whack_judge.sv
// Player-side judge: decides hit / wrong key / escape, keeps BCD score and lives.
module whack_judge
  import whack_pkg::*;
#(
  parameter int LIVES = 3
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       game,
  input  logic [2:0] mole,
  input  logic [2:0] key,
  output logic       turnoff,
  output logic [3:0] score_tens,
  output logic [3:0] score_ones,
  output logic [2:0] lives,
  output logic       game_over,
  output logic       hit_pulse,
  output logic       miss_pulse
);

  state_t     state, state_nx;
  score_t     score, score_nx;
  logic [2:0] target, target_nx;
  logic [2:0] lives_nx;
  logic [2:0] press;
  logic       game_d, game_start, lit;
  logic       over_nx, turnoff_nx, do_hit, do_miss;

  key_edge #(.W(3)) u_key_edge (
    .clock   (clock),
    .reset_n (reset_n),
    .key     (key),
    .press   (press)
  );

  assign game_start = game & ~game_d;
  assign lit        = mole_lit(mole);
  assign score_tens = score.tens;
  assign score_ones = score.ones;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      score      <= '0;
      target     <= '0;
      lives      <= 3'(LIVES);
      game_over  <= 1'b0;
      turnoff    <= 1'b0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      game_d     <= 1'b0;
    end else begin
      state      <= state_nx;
      score      <= score_nx;
      target     <= target_nx;
      lives      <= lives_nx;
      game_over  <= over_nx;
      turnoff    <= turnoff_nx;
      hit_pulse  <= do_hit;
      miss_pulse <= do_miss;
      game_d     <= game;
    end
  end

  always_comb begin
    state_nx   = state;
    score_nx   = score;
    target_nx  = target;
    lives_nx   = lives;
    over_nx    = game_over;
    turnoff_nx = 1'b0;
    do_hit     = 1'b0;
    do_miss    = 1'b0;

    if (!game) begin
      state_nx = IDLE;
    end else if (game_start) begin
      state_nx = WAIT;
      score_nx = '0;
      lives_nx = 3'(LIVES);
      over_nx  = 1'b0;
    end else begin
      unique case (state)
        IDLE: ;
        WAIT: begin
          if (|press) begin
            do_miss = 1'b1;
          end else if (lit) begin
            target_nx = mole;
            state_nx  = ARMED;
          end
        end
        ARMED: begin
          // A wrong key outranks a simultaneous correct key.
          if (|(press & ~target)) begin
            do_miss = 1'b1;
          end else if (|(press & target)) begin
            do_hit     = 1'b1;
            turnoff_nx = 1'b1;
            state_nx   = CLEAR;
          end else if (!lit) begin
            do_miss  = 1'b1;
            state_nx = WAIT;
          end
        end
        CLEAR: begin
          if (mole == 3'b000) begin
            state_nx = WAIT;
          end else begin
            turnoff_nx = 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end

    if (do_hit) score_nx = bcd_inc(score);

    if (do_miss) begin
      if (lives != 3'd0) lives_nx = lives - 3'd1;
      if (lives <= 3'd1) begin
        over_nx  = 1'b1;
        state_nx = IDLE;
      end
    end
  end

endmodule

// File: doc/whack_judge.md
# whack_judge

Player-side judge for the whack-a-mole game: the other end of the mole display interface. It watches the three mole lines produced by the display controller and the player's three push-buttons, decides hit, wrong key or escape, and keeps a BCD score and a lives count. It drives `turnoff` back to the display controller to retire a hit mole, and reports `game_over` to the top-level game FSM.

## Interface
- `LIVES`, default 3: lives loaded at game start, 1..7.
- `clock  in  1`: system clock, rising edge.
- `reset_n  in  1`: asynchronous, active-low reset.
- `game  in  1`: game running; a rising edge starts a new game.
- `mole  in  3`: mole lines {mole3, mole2, mole1}, one-hot or zero.
- `key  in  3`: raw push-buttons {key3, key2, key1}, active-high press, asynchronous to `clock`.
- `turnoff  out  1`: request to the display controller to clear the current mole (level).
- `score_tens  out  4`: BCD tens digit.
- `score_ones  out  4`: BCD ones digit.
- `lives  out  3`: remaining lives.
- `game_over  out  1`: lives exhausted; held until the next game start.
- `hit_pulse  out  1`: one-cycle pulse per scored hit.
- `miss_pulse  out  1`: one-cycle pulse per lost life.

## Operation
- Key path: per-key 2-FF synchronizer, then rising-edge detect, giving `press[2:0]` (one-cycle pulses). A held key yields exactly one press.
- Mole validity: `mole` counts as lit only when exactly one bit is set. Zero or multi-hot counts as no mole.
- Game start (rising edge of `game`): score 00, `lives`=LIVES, `game_over`=0, next state WAIT.
- `game` low: state IDLE. Score, lives and `game_over` hold their values. Presses are ignored.
- State machine (states IDLE, WAIT, ARMED, CLEAR):
  - IDLE -> WAIT on the `game` rising edge.
  - WAIT (no lit mole): a lit mole latches its one-hot value into `target` and moves to ARMED. Any press in WAIT is a wrong key and costs a miss.
  - ARMED:
    - If any pressed bit is outside `target`, the result is a miss and the state stays ARMED. A wrong key wins over a simultaneous correct key.
    - Else if `press & target` is nonzero, the result is a hit and the state moves to CLEAR.
    - Else if the mole goes unlit, the mole escaped: miss, then WAIT.
  - CLEAR: `turnoff`=1. Presses are ignored. When `mole`==0, `turnoff` drops and the state moves to WAIT.
- Hit: score +1 in BCD (ones wraps 9->0 with carry into tens). The score saturates at 99.
- Miss: `lives` -1.
  - If `lives` reaches 0, set `game_over`=1 and go to IDLE. `turnoff` is low there.
  - Further events are ignored until the next game start.
- Arithmetic: `lives` never underflows. A score at 99 stays 99 while `hit_pulse` still fires.

## Timing
- Reset values: state IDLE, `turnoff`=0, score 00, `lives`=LIVES, `game_over`=0, both pulses 0, synchronizers 0.
- Press latency: a `key` change sampled at edge N produces `press` in cycle N+2. The judged outputs (score, lives, pulses, `turnoff`) update at edge N+3.
- `turnoff` is registered and asserts on the same edge as the score increment. It holds at least until the cycle after `mole` is observed all-zero, and has no maximum hold.
- Escape detection: one cycle after `mole` falls while in ARMED.
- Simultaneous events, mole falls in the same cycle as a correct press: counts as a hit, and CLEAR exits on the next cycle.
- `game` falling mid-CLEAR: `turnoff` drops on the next edge and no score change is made.
- Asynchronous reset mid-operation: all outputs return to reset values immediately.

## Structure
- Shared package/include `whack_pkg`:
  - state encodings (IDLE=0, WAIT=1, ARMED=2, CLEAR=3)
  - `SCORE_MAX` (99)
  - mole index constants shared with the display controller
- Sub-module `key_edge`: synchronizer plus rising-edge detector, 3 bits wide, with `clock`/`reset_n`. It is instantiated once.
- Everything else (FSM, BCD counter, lives counter) lives in `whack_judge`.

## Test plan
- Reset, raise `game`, light mole=3'b010, press key=3'b010 -> at edge press+3: `hit_pulse`=1, score 01, `turnoff`=1. Drop mole -> `turnoff`=0 the cycle after, state WAIT.
- mole=3'b001, press key=3'b101 (correct plus wrong) -> `miss_pulse`=1, `lives` 3->2, score unchanged, `turnoff` stays 0.
- mole=3'b100 lit for 20 cycles then 0 with no press -> `miss_pulse` one cycle later, `lives` -1.
- Preload score to 98, score 3 hits -> score 99, 99, 99, with `hit_pulse` each time.
- Cause 3 misses with LIVES=3 -> `lives`=0, `game_over`=1, later presses ignored. Toggle `game` low then high -> score 00, `lives` 3, `game_over` 0.
- Hold the key for 50 cycles with the mole re-lit mid-hold -> only one press counted. Assert `reset_n`=0 mid-CLEAR -> `turnoff` and score clear without waiting for a clock edge.
